// File: rtl/jamma_input_scanner.sv
// Time-multiplexed JAMMA input scanner: drives jselect, samples the shared jjoy bus per player slot.
// Optional per-bit debounce on joystick and coin outputs is enabled by defining JAMMA_DEBOUNCE_EN.
module jamma_input_scanner #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       pclk,
  input  logic       pll_lckd,
  input  logic [7:0] jjoy,
  input  logic [1:0] jcoin,
  input  logic [5:0] kbd_joy,
  output logic       jselect,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin,
  output logic       scan_done
);

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("jamma_input_scanner: SETTLE_CYCLES out of range 3..255");
  end
  if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 8) begin : g_bad_debounce
    $error("jamma_input_scanner: DEBOUNCE_SCANS out of range 2..8");
  end

  typedef enum logic [1:0] {
    P1_SETTLE = 2'd0,
    P1_SAMPLE = 2'd1,
    P2_SETTLE = 2'd2,
    P2_SAMPLE = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       jselect_q, jselect_d;
  logic       scan_done_q, scan_done_d;
  logic [7:0] jjoy_s1_q, jjoy_s2_q;
  logic [1:0] jcoin_s1_q, jcoin_s2_q;
  logic [7:0] joy1_q, joy1_d;
  logic [7:0] joy2_q, joy2_d;
  logic [1:0] coin_q, coin_d;

  logic       samp_p1_s, samp_p2_s;
  logic [7:0] p1_raw_s;

  // Two-stage synchronisers for the asynchronous JAMMA bus and coin inputs
  always_ff @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      jjoy_s1_q  <= 8'hFF;
      jjoy_s2_q  <= 8'hFF;
      jcoin_s1_q <= 2'b11;
      jcoin_s2_q <= 2'b11;
    end else begin
      jjoy_s1_q  <= jjoy;
      jjoy_s2_q  <= jjoy_s1_q;
      jcoin_s1_q <= jcoin;
      jcoin_s2_q <= jcoin_s1_q;
    end
  end

  // Scan sequencer: settle counter and state transitions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      P1_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = P1_SAMPLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      P1_SAMPLE: begin
        state_d = P2_SETTLE;
        cnt_d   = 8'd0;
      end
      P2_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = P2_SAMPLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      P2_SAMPLE: begin
        state_d = P1_SETTLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = P1_SETTLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // jselect follows the slot being entered, so it only moves on entry to a SETTLE state
  always_comb begin
    jselect_d   = (state_d == P2_SETTLE) || (state_d == P2_SAMPLE);
    scan_done_d = (state_q == P2_SAMPLE);
    samp_p1_s   = (state_q == P1_SAMPLE);
    samp_p2_s   = (state_q == P2_SAMPLE);
    p1_raw_s    = jjoy_s2_q & {2'b11, kbd_joy};
  end

  // Sequencer and control output registers
  always_ff @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      state_q     <= P1_SETTLE;
      cnt_q       <= 8'd0;
      jselect_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jselect_q   <= jselect_d;
      scan_done_q <= scan_done_d;
    end
  end

`ifdef JAMMA_DEBOUNCE_EN
  localparam int DB = DEBOUNCE_SCANS;

  logic [7:0][DB-1:0] hist1_q, hist1_d;
  logic [7:0][DB-1:0] hist2_q, hist2_d;
  logic [1:0][DB-1:0] histc_q, histc_d;

  function automatic logic [DB-1:0] hist_push(input logic [DB-1:0] h, input logic s);
    return {h[DB-2:0], s};
  endfunction

  // A bit only moves once its whole window (history plus new sample) agrees
  function automatic logic db_resolve(input logic [DB-1:0] h, input logic cur);
    if (&h) begin
      return 1'b1;
    end else if (~|h) begin
      return 1'b0;
    end else begin
      return cur;
    end
  endfunction

  // Per-bit history shift and debounced output decision at each slot's sample
  always_comb begin
    hist1_d = hist1_q;
    hist2_d = hist2_q;
    histc_d = histc_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    coin_d  = coin_q;
    if (samp_p1_s) begin
      for (int b = 0; b < 8; b++) begin
        hist1_d[b] = hist_push(hist1_q[b], p1_raw_s[b]);
        joy1_d[b]  = db_resolve(hist1_d[b], joy1_q[b]);
      end
    end else begin
      joy1_d = joy1_q;
    end
    if (samp_p2_s) begin
      for (int b = 0; b < 8; b++) begin
        hist2_d[b] = hist_push(hist2_q[b], jjoy_s2_q[b]);
        joy2_d[b]  = db_resolve(hist2_d[b], joy2_q[b]);
      end
    end else begin
      joy2_d = joy2_q;
    end
    if (samp_p1_s || samp_p2_s) begin
      for (int k = 0; k < 2; k++) begin
        histc_d[k] = hist_push(histc_q[k], jcoin_s2_q[k]);
        coin_d[k]  = db_resolve(histc_d[k], coin_q[k]);
      end
    end else begin
      coin_d = coin_q;
    end
  end

  // Debounce history registers
  always_ff @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      hist1_q <= '1;
      hist2_q <= '1;
      histc_q <= '1;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      histc_q <= histc_d;
    end
  end
`else
  // Raw sample is loaded directly into the matching output register
  always_comb begin
    if (samp_p1_s) begin
      joy1_d = p1_raw_s;
    end else begin
      joy1_d = joy1_q;
    end
    if (samp_p2_s) begin
      joy2_d = jjoy_s2_q;
    end else begin
      joy2_d = joy2_q;
    end
    if (samp_p1_s || samp_p2_s) begin
      coin_d = jcoin_s2_q;
    end else begin
      coin_d = coin_q;
    end
  end
`endif

  // Registered joystick and coin outputs
  always_ff @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      joy1_q <= 8'hFF;
      joy2_q <= 8'hFF;
      coin_q <= 2'b11;
    end else begin
      joy1_q <= joy1_d;
      joy2_q <= joy2_d;
      coin_q <= coin_d;
    end
  end

  assign jselect   = jselect_q;
  assign scan_done = scan_done_q;
  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;
  assign coin      = coin_q;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Scoreboard bench for jamma_input_scanner: driver pushes expected per-scan outputs,
// a monitor pops and compares on every scan_done pulse.
module tb_jamma_input_scanner;

  localparam int SETTLE = 8;
  localparam int DB     = 4;
  localparam int PERIOD = 2 * (SETTLE + 1);
`ifdef JAMMA_DEBOUNCE_EN
  localparam int DEPTH = DB;
`else
  localparam int DEPTH = 1;
`endif

  logic       pclk = 1'b0;
  logic       pll_lckd = 1'b0;
  logic [7:0] jjoy = 8'hFF;
  logic [1:0] jcoin = 2'b11;
  logic [5:0] kbd_joy = 6'h3F;
  logic       jselect;
  logic [7:0] joystick1, joystick2;
  logic [1:0] coin;
  logic       scan_done;

  int total = 0;
  int bad   = 0;

  jamma_input_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DB)) dut (
    .pclk(pclk), .pll_lckd(pll_lckd), .jjoy(jjoy), .jcoin(jcoin), .kbd_joy(kbd_joy),
    .jselect(jselect), .joystick1(joystick1), .joystick2(joystick2), .coin(coin),
    .scan_done(scan_done)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [5:0] kb;
    logic [1:0] jc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV] = '{
    '{8'hFF, 8'hFF, 6'h3F, 2'b11},
    '{8'hFE, 8'hFF, 6'h3F, 2'b11},
    '{8'hFF, 8'hFF, 6'h3D, 2'b11},
    '{8'hFF, 8'hFE, 6'h3F, 2'b10},
    '{8'hFF, 8'hFE, 6'h3F, 2'b10},
    '{8'hFF, 8'hFE, 6'h3F, 2'b10},
    '{8'hFF, 8'hFF, 6'h3F, 2'b10},
    '{8'hFF, 8'hFE, 6'h3F, 2'b11},
    '{8'hFF, 8'hFE, 6'h3F, 2'b11},
    '{8'hFF, 8'hFE, 6'h3F, 2'b11},
    '{8'hFF, 8'hFE, 6'h3F, 2'b11},
    '{8'h7F, 8'hBF, 6'h3E, 2'b01},
    '{8'h5A, 8'hA5, 6'h3F, 2'b00},
    '{8'h00, 8'h00, 6'h3F, 2'b11},
    '{8'h00, 8'h00, 6'h3F, 2'b11},
    '{8'h00, 8'h00, 6'h3F, 2'b11},
    '{8'h00, 8'h00, 6'h3F, 2'b11},
    '{8'h00, 8'h00, 6'h3F, 2'b11}
  };

  logic [17:0] exp_q [$];

  // Reference model: a bit changes once DEPTH consecutive samples agree
  logic [7:0] l1, l2, e1, e2;
  logic [1:0] lc, ec;
  int r1 [8];
  int r2 [8];
  int rc [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    l1 = 8'hFF; l2 = 8'hFF; e1 = 8'hFF; e2 = 8'hFF;
    lc = 2'b11; ec = 2'b11;
    for (int b = 0; b < 8; b++) begin r1[b] = DEPTH; r2[b] = DEPTH; end
    for (int k = 0; k < 2; k++) rc[k] = DEPTH;
  endtask

  task automatic model_coin(input logic [1:0] c);
    for (int k = 0; k < 2; k++) begin
      if (c[k] == lc[k]) rc[k]++;
      else begin rc[k] = 1; lc[k] = c[k]; end
      if (rc[k] >= DEPTH) ec[k] = c[k];
    end
  endtask

  task automatic model_scan(input vec_t v);
    logic [7:0] s1;
    s1 = v.p1 & {2'b11, v.kb};
    for (int b = 0; b < 8; b++) begin
      if (s1[b] == l1[b]) r1[b]++;
      else begin r1[b] = 1; l1[b] = s1[b]; end
      if (r1[b] >= DEPTH) e1[b] = s1[b];
    end
    model_coin(v.jc);
    for (int b = 0; b < 8; b++) begin
      if (v.p2[b] == l2[b]) r2[b]++;
      else begin r2[b] = 1; l2[b] = v.p2[b]; end
      if (r2[b] >= DEPTH) e2[b] = v.p2[b];
    end
    model_coin(v.jc);
  endtask

  // Drives one full scan (P1 value, then P2 value once jselect rises); called at a negedge
  task automatic run_scan(input vec_t v);
    int n;
    model_scan(v);
    exp_q.push_back({e1, e2, ec});
    jjoy = v.p1; kbd_joy = v.kb; jcoin = v.jc;
    n = 0;
    do begin @(negedge pclk); n++; end while (!jselect && n < 40);
    chk("jsel_rise", n, SETTLE + 1);
    jjoy = v.p2;
    n = 0;
    do begin @(negedge pclk); n++; end while (!scan_done && n < 40);
    chk("p2_slot_len", n, SETTLE + 1);
  endtask

  // Monitor: compares committed outputs and scan period at every scan_done
  int cyc = 0;
  always @(negedge pclk) begin
    logic [17:0] e;
    if (!pll_lckd) begin
      cyc = 0;
    end else begin
      cyc++;
      if (scan_done) begin
        chk("scan_period", cyc, PERIOD);
        cyc = 0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard: scan_done with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("scan_outputs", {joystick1, joystick2, coin}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    #12;
    chk("reset_state", {jselect, joystick1, joystick2, coin, scan_done}, {1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0});
    @(negedge pclk);
    #1 pll_lckd = 1'b1;
    for (int i = 0; i < NV; i++) run_scan(vecs[i]);

    // Reset pulse in the middle of P2_SETTLE
    n = 0;
    do begin @(negedge pclk); n++; end while (!jselect && n < 40);
    chk("pre_reset_jsel", n, SETTLE + 1);
    chk("pre_reset_joy2", joystick2, e2);
    #1 pll_lckd = 1'b0;
    #1 chk("mid_reset", {jselect, joystick1, joystick2, coin, scan_done}, {1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0});
    @(negedge pclk);
    @(negedge pclk);
    model_reset();
    #1 pll_lckd = 1'b1;
    run_scan('{8'hFF, 8'hFF, 6'h3F, 2'b11});
    run_scan('{8'hFE, 8'hFD, 6'h3F, 2'b10});
    @(negedge pclk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jamma_input_scanner.md
# jamma_input_scanner

Time-multiplexed JAMMA input front end for the arcade cores. Drives the external select line (JSELECT), waits for the board multiplexer to settle, samples the shared 8-bit JJOY bus once per player slot, and presents stable, optionally debounced, active-low joystick and coin vectors. It sits directly upstream of the PACMAN core's I_JOYSTICK_A/B, I_PLAYER and I_COIN inputs, replacing the free-running select toggle.

## Interface
Parameters:
- SETTLE_CYCLES, 8: clocks held in each settle state after a select change; legal range 3..255 (covers 2-flop sync plus mux delay).
- DEBOUNCE_SCANS, 4: consecutive equal samples needed to change a debounced bit; legal 2..8; ignored when JAMMA_DEBOUNCE_EN is undefined.

Ports:
- pclk  in  1  core pixel clock; only clock.
- pll_lckd  in  1  reset; asynchronous, active-low (low = reset).
- jjoy  in  8  raw JAMMA bus, active-low, asynchronous; bit7 = start, bits5:0 = joystick/buttons.
- jcoin  in  2  raw coin inputs, active-low, asynchronous.
- kbd_joy  in  6  on-board joystick, active-low, merged into player 1.
- jselect  out  1  mux select; 0 = player 1 slot, 1 = player 2 slot.
- joystick1  out  8  player 1, active-low, registered.
- joystick2  out  8  player 2, active-low, registered.
- coin  out  2  coins, active-low, registered.
- scan_done  out  1  one-cycle pulse when a full P1+P2 scan has been committed.

## Operation
- jjoy and jcoin pass continuously through 2-stage synchronisers (reset to all ones).
- FSM states: P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE, cycling in that order.
- jselect = 0 in P1_*, 1 in P2_*; registered, changes on entry to each SETTLE state.
- Settle counter clears on entry to SETTLE, increments each clock; at count = SETTLE_CYCLES-1 the next state is SAMPLE.
- SAMPLE lasts exactly one clock; next state is the other player's SETTLE.
- P1 sample value = sync_jjoy & {2'b11, kbd_joy}; P2 sample value = sync_jjoy.
- Coins are sampled in both SAMPLE states (twice per scan).
- Input changes between samples are invisible; a glitch shorter than one scan is seen only if it coincides with a sample.
- scan_done asserts for one clock on the edge that leaves P2_SAMPLE.

## Timing
- Reset (pll_lckd low, takes effect immediately, mid-scan included): state P1_SETTLE, counter 0, jselect 0, joystick1/2 8'hFF, coin 2'b11, scan_done 0, all history registers all ones.
- First P1 sample occurs SETTLE_CYCLES clocks after reset release; scan period = 2*(SETTLE_CYCLES+1) clocks (18 at default).
- Without debounce: output register loads on the edge ending the matching SAMPLE state (1 clock after sample decision); input-to-output latency ≤ scan period + SETTLE_CYCLES + 3 clocks.
- With debounce: each bit keeps a DEBOUNCE_SCANS-deep history shifted at its slot's SAMPLE; output bit updates on that same edge when the history plus new sample is all 0 or all 1, otherwise it holds.
- Coin history shifts at every SAMPLE, so coin debounce time is half the joystick debounce time.
- Simultaneous change on both players' bits: each handled independently in its own slot.

## Configuration
- JAMMA_DEBOUNCE_EN defined: per-bit debounce as above on joystick1, joystick2 and coin.
- Undefined: history logic removed; outputs load the raw sample directly at each SAMPLE; DEBOUNCE_SCANS unused.

## Test plan
- Reset release, jjoy=8'hFF: jselect toggles 0→1 after 9 clocks, period 18; outputs stay 8'hFF/2'b11; scan_done pulses every 18 clocks.
- Debounce off, jjoy=8'hFE while jselect=0 only: joystick1=8'hFE after first P1 sample; joystick2 stays 8'hFF.
- kbd_joy=6'b111101, jjoy=8'hFF: joystick1=8'hFD, joystick2=8'hFF.
- Debounce on (4 scans), jjoy bit0 low for exactly 3 P2 samples then high: joystick2 stays 8'hFF; low for 4 samples: joystick2=8'hFE on the 4th P2 sample edge.
- jcoin=2'b10 held: coin=2'b10 after 4 SAMPLEs (debounce on) / after 1 (off).
- pll_lckd pulsed low during P2_SETTLE with joystick2=8'h00: immediately jselect=0, joystick2=8'hFF, scan restarts at P1_SETTLE.
